fifo_word_packer: RTL and testbench

Read-side consumer for `fifo`: pops narrow FIFO_WIDTH words from the FIFO whenever data is available and packs PACK consecutive words into one wide word. It presents packed words on a valid/ready stream to downstream logic, with a flush input that emits a partially filled word. It is the drain end of the FIFO write/read pair, sitting between `fifo` and the wide datapath.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_word_packer_pack_out_reg.sv | 47 ++++
 rtl/fifo_word_packer.sv | 115 +++++++++++
 tb/tb_fifo_word_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the FIFO and its read-side word packer.
//   DEFAULT_FIFO_WIDTH : default width of one FIFO word
//   DEFAULT_PACK       : default number of FIFO words per packed word
//   DEFAULT_OUT_WIDTH  : default packed word width
//   lane_cnt_width()   : width of a lane count able to hold 0..PACK
//   lane_cnt_t         : lane count type for the default PACK
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_FIFO_WIDTH = 2;
    localparam int DEFAULT_PACK       = 4;
    localparam int DEFAULT_OUT_WIDTH  = DEFAULT_FIFO_WIDTH * DEFAULT_PACK;

    // A count of valid lanes must represent PACK itself, hence PACK+1 values.
    function automatic int lane_cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

    typedef logic [$clog2(DEFAULT_PACK + 1)-1:0] lane_cnt_t;

endpackage

// File: rtl/fifo_word_packer_pack_out_reg.sv
// ---------------------------------------------------------------------------
// pack_out_reg
// One-entry valid/ready output register for the word packer.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : capture load_data/load_lanes and raise out_valid
//   load_data/lanes : word and valid-lane count to capture
//   out_ready       : downstream accepts when out_valid && out_ready
//   out_data/lanes  : registered word and lane count
//   out_valid       : registered valid
//   out_free        : register can take a new word at this edge
// ---------------------------------------------------------------------------
module pack_out_reg
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_OUT_WIDTH,
    parameter int LANE_W = lane_cnt_width(DEFAULT_PACK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LANE_W-1:0] load_lanes,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LANE_W-1:0] out_lanes,
    output logic              out_valid,
    output logic              out_free
);

    // Free when empty, or when the held word leaves at this same edge.
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_lanes <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_lanes <= load_lanes;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// ---------------------------------------------------------------------------
// fifo_word_packer
// Drains a show-ahead FIFO and packs PACK consecutive words into one wide
// word presented on a valid/ready stream. A flush pulse emits a partially
// filled word; unfilled lanes read as zero.
//   clk, reset    : clock, asynchronous active-high reset
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO head word (valid while fifo_empty=0)
//   fifo_rd_en    : pop the FIFO head at this edge (combinational)
//   flush         : one-cycle request to emit the partial word
//   out_data      : packed word, lane k at [k*FIFO_WIDTH +: FIFO_WIDTH]
//   out_lanes     : number of valid lanes in out_data
//   out_valid     : out_data/out_lanes valid
//   out_ready     : downstream accept
// ---------------------------------------------------------------------------
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter  int PACK       = DEFAULT_PACK,
    localparam int OUT_WIDTH  = FIFO_WIDTH * PACK,
    localparam int LANE_W     = lane_cnt_width(PACK)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [LANE_W-1:0]     out_lanes,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int IDX_W = $clog2(PACK);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(PACK - 1);

    logic [IDX_W-1:0]     lane;
    logic                 flush_pending;
    logic [OUT_WIDTH-1:0] asm_word;
    logic [OUT_WIDTH-1:0] asm_next;

    logic                 out_free;
    logic                 pop;
    logic                 pop_last;
    logic                 flush_req;
    logic                 load;
    logic [OUT_WIDTH-1:0] load_data;
    logic [LANE_W-1:0]    load_lanes;

    // The last lane may only be popped when the output register can take
    // the completed word at the same edge; earlier lanes never wait.
    // Reset gates the pop so the FIFO is never drained while held in reset.
    assign pop = !reset && !fifo_empty && !flush_pending && !flush &&
                 ((lane != LAST_LANE) || out_free);
    assign fifo_rd_en = pop;

    assign pop_last = pop && (lane == LAST_LANE);

    // A flush with lane=0 has nothing to emit and is dropped. Otherwise the
    // partial word goes out at the first edge the output register is free,
    // which may be the flush edge itself.
    assign flush_req = flush_pending || (flush && (lane != '0));
    assign load      = pop_last || (flush_req && out_free);

    // Assembly register with the current FIFO head written into `lane`;
    // a completed word is forwarded from here so the last pop is not delayed.
    always_comb begin
        asm_next = asm_word;
        asm_next[int'(lane) * FIFO_WIDTH +: FIFO_WIDTH] = fifo_rd_data;
    end

    assign load_data  = pop_last ? asm_next : asm_word;
    assign load_lanes = pop_last ? LANE_W'(PACK) : LANE_W'(lane);

    // Assembly state. Clearing on every load keeps stale upper lanes out of
    // a later partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_word      <= '0;
            lane          <= '0;
            flush_pending <= 1'b0;
        end else if (load) begin
            asm_word      <= '0;
            lane          <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (pop) begin
                asm_word <= asm_next;
                lane     <= lane + 1'b1;
            end
            if (flush && (lane != '0)) begin
                flush_pending <= 1'b1;
            end
        end
    end

    pack_out_reg #(
        .DATA_W (OUT_WIDTH),
        .LANE_W (LANE_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .load_lanes (load_lanes),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lanes  (out_lanes),
        .out_valid  (out_valid),
        .out_free   (out_free)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

    localparam int FW = 2;
    localparam int PK = 4;
    localparam int OW = FW * PK;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [FW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          flush;
    logic [OW-1:0] out_data;
    logic [LW-1:0] out_lanes;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .FIFO_WIDTH (FW),
        .PACK       (PK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_data     (out_data),
        .out_lanes    (out_lanes),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    logic [FW-1:0]    fifo_q[$];
    logic [LW+OW-1:0] sb_q[$];
    logic [OW-1:0]    m_asm;
    int               m_cnt;
    int               n_checks;
    int               n_errors;
    logic             last_rd_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    // One clock cycle: sample just before the edge, update the reference
    // model and scoreboard, then advance past the edge.
    task automatic cycle();
        logic [LW+OW-1:0] exp;
        logic [FW-1:0]    d;
        #1;
        last_rd_en = fifo_rd_en;
        if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp = sb_q.pop_front();
                check("sb_out_data", 32'(out_data), 32'(exp[OW-1:0]));
                check("sb_out_lanes", 32'(out_lanes), 32'(exp[LW+OW-1:OW]));
            end
        end
        if (!reset) begin
            if (flush && m_cnt > 0) begin
                sb_q.push_back({LW'(m_cnt), m_asm});
                m_asm = '0;
                m_cnt = 0;
            end
            if (fifo_rd_en && fifo_q.size() > 0) begin
                d = fifo_q.pop_front();
                m_asm[m_cnt*FW +: FW] = d;
                m_cnt++;
                if (m_cnt == PK) begin
                    sb_q.push_back({LW'(PK), m_asm});
                    m_asm = '0;
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (!out_valid && k < max_cyc) begin
            cycle();
            k++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] t2_words[8];
        n_checks  = 0;
        n_errors  = 0;
        m_asm     = '0;
        m_cnt     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        // FIFO looks non-empty during reset: no pop may be requested.
        fifo_empty   = 1'b0;
        fifo_rd_data = 2'b11;
        #2;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_lanes", 32'(out_lanes), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        refresh();

        // Back-to-back full word
        out_ready = 1'b1;
        fifo_q.push_back(2'b01);
        fifo_q.push_back(2'b10);
        fifo_q.push_back(2'b11);
        fifo_q.push_back(2'b00);
        refresh();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t1_rd_en", 32'(last_rd_en), 32'd1);
        end
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h39);
        check("t1_lanes", 32'(out_lanes), 32'd4);
        cycle();
        cycle();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        t2_words = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 8; i++) fifo_q.push_back(t2_words[i]);
        refresh();
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("t2_rd_en", 32'(last_rd_en), 32'd1);
            if (i == 3) check("t2_first_valid", 32'(out_valid), 32'd1);
        end
        cycle();
        check("t2_stall", 32'(last_rd_en), 32'd0);
        out_ready = 1'b1;
        cycle();
        check("t2_resume_pop", 32'(last_rd_en), 32'd1);
        out_ready = 1'b0;
        check("t2_second_valid", 32'(out_valid), 32'd1);
        check("t2_second_data", 32'(out_data), 32'h6F);
        check("t2_second_lanes", 32'(out_lanes), 32'd4);
        out_ready = 1'b1;
        cycle();
        cycle();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Flush of a partial word
        fifo_q.push_back(2'b11);
        fifo_q.push_back(2'b01);
        fifo_q.push_back(2'b10);
        refresh();
        cycle();
        cycle();
        flush     = 1'b1;
        out_ready = 1'b0;
        cycle();
        check("t3_no_pop_on_flush", 32'(last_rd_en), 32'd0);
        flush = 1'b0;
        wait_valid("t3", 4);
        check("t3_data", 32'(out_data), 32'h07);
        check("t3_lanes", 32'(out_lanes), 32'd2);
        cycle();
        check("t3_pop_after_flush", 32'(last_rd_en), 32'd1);
        out_ready = 1'b1;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t3_drained", 32'(out_valid), 32'd0);

        // Idle with empty FIFO, then flush with nothing assembled
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0];
            cycle();
            check("t4_idle_rd_en", 32'(last_rd_en), 32'd0);
            check("t4_idle_valid", 32'(out_valid), 32'd0);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_empty_flush", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-word
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(2'b01);
        refresh();
        for (int i = 0; i < 6; i++) cycle();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_rd_en", 32'(fifo_rd_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_lanes", 32'(out_lanes), 32'd0);
        sb_q.delete();
        fifo_q.delete();
        m_asm = '0;
        m_cnt = 0;
        refresh();
        cycle();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(2'b10);
        refresh();
        wait_valid("t5", 6);
        check("t5_data", 32'(out_data), 32'hAA);
        check("t5_lanes", 32'(out_lanes), 32'd4);
        out_ready = 1'b1;
        cycle();
        cycle();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
